noc_traffic_injector: RTL

- Parametrised PE-side traffic source for the 2D-mesh NoC; drives one router Local input port via the ReqDnStr/GntDnStr/DnStrFull handshake.
- Successor to the per-node hard-coded injectors: mesh size, source position, packet count and injection gap are parameters/ports.
- Destination selection is run-time selectable: uniform-random, transpose, bit-complement or hotspot.
- Randomness comes from an internal synthesizable LFSR, so runs are reproducible from the seed and need no $random.

---
 rtl/noc_pkg.sv | 33 +++
 rtl/noc_traffic_injector_if.sv | 12 +
 rtl/noc_lfsr16.sv | 13 +
 rtl/noc_traffic_injector.sv | 123 ++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC traffic injector: mode and state encodings,
// packet field layout and the sign-magnitude offset encoder.
package noc_pkg;

    typedef enum logic [1:0] {
        MODE_UNIFORM   = 2'd0,
        MODE_TRANSPOSE = 2'd1,
        MODE_BITCOMP   = 2'd2,
        MODE_HOTSPOT   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        GAP,
        WAIT_GNT,
        DONE
    } state_e;

    localparam int DST_X_HI = 31;
    localparam int DST_Y_HI = 27;
    localparam int PID_LO   = 6;
    localparam int ID_W     = 6;

    // Positive difference sets the direction bit; zero always encodes as 0_000.
    function automatic logic [3:0] encOffset(input int diff);
        logic [3:0] r;
        if (diff > 0) r = {1'b1, 3'(diff)};
        else          r = {1'b0, 3'(-diff)};
        return r;
    endfunction

endpackage

// File: rtl/noc_traffic_injector_if.sv
// Router Local-port handshake seen from the injector (master) and router (slave).
interface noc_traffic_injector_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  ReqDnStr;
    logic                  GntDnStr;
    logic                  DnStrFull;
    logic [DATA_WIDTH-1:0] PacketOut;

    modport master (output ReqDnStr, output PacketOut, input GntDnStr, input DnStrFull);
    modport slave  (input ReqDnStr, input PacketOut, output GntDnStr, output DnStrFull);
endinterface

// File: rtl/noc_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), free-running out of reset.
module noc_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= SEED;
        else       q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
    end
endmodule

// File: rtl/noc_traffic_injector.sv
// PE-side NoC traffic source: picks a destination per packet from an internal
// LFSR and drives one router Local port through the Req/Gnt/Full handshake.
module noc_traffic_injector
    import noc_pkg::*;
#(
    parameter int              X_SIZE     = 5,
    parameter int              Y_SIZE     = 5,
    parameter int              SRC_X      = 2,
    parameter int              SRC_Y      = 4,
    parameter logic [ID_W-1:0] MODULE_ID  = 6'b010_100,
    parameter int              DATA_WIDTH = 32,
    parameter int              PID_W      = 10,
    parameter int              MAX_PKTS   = 1023,
    parameter logic [15:0]     LFSR_SEED  = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [3:0]             max_gap,
    input  logic [2:0]             hot_x,
    input  logic [2:0]             hot_y,
    noc_traffic_injector_if.master bus,
    output logic [PID_W-1:0]       pkt_count,
    output logic                   done
);
    state_e           state, stateNext;
    logic [15:0]      lfsr;
    logic [PID_W-1:0] packetId;
    logic [3:0]       gap, cnt, gapNext;
    logic [3:0]       xOfs, yOfs, xOfsNext, yOfsNext;
    logic             prepStb, cntInc, loadStb, grantStb;
    int               idx, dstX, dstY, hotX, hotY;

    noc_lfsr16 #(.SEED(LFSR_SEED)) uLfsr (.clk(clk), .reset(reset), .q(lfsr));

    // Destination for the packet being prepared, from the current LFSR state.
    always_comb begin
        idx  = int'(lfsr) % (X_SIZE * Y_SIZE);
        hotX = (int'(hot_x) > X_SIZE - 1) ? X_SIZE - 1 : int'(hot_x);
        hotY = (int'(hot_y) > Y_SIZE - 1) ? Y_SIZE - 1 : int'(hot_y);
        dstX = idx % X_SIZE;
        dstY = idx / X_SIZE;
        case (mode_e'(mode))
            MODE_TRANSPOSE: if (X_SIZE == Y_SIZE) begin dstX = SRC_Y; dstY = SRC_X; end
            MODE_BITCOMP:   begin dstX = X_SIZE - 1 - SRC_X; dstY = Y_SIZE - 1 - SRC_Y; end
            MODE_HOTSPOT:   if (lfsr[15:12] < 4'd4) begin dstX = hotX; dstY = hotY; end
            default:        ;
        endcase
        if (dstX == SRC_X && dstY == SRC_Y) dstX = (SRC_X + 1) % X_SIZE;
        xOfsNext = encOffset(dstX - SRC_X);
        yOfsNext = encOffset(SRC_Y - dstY);
        gapNext  = 4'(int'(lfsr[7:4]) % (int'(max_gap) + 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        prepStb   = 1'b0;
        cntInc    = 1'b0;
        loadStb   = 1'b0;
        grantStb  = 1'b0;
        case (state)
            IDLE: if (enable && !done) stateNext = PREP;
            PREP: begin
                prepStb   = 1'b1;
                stateNext = GAP;
            end
            GAP: begin
                if (cnt < gap) cntInc = 1'b1;
                else if (!bus.DnStrFull) begin
                    loadStb   = 1'b1;
                    stateNext = WAIT_GNT;
                end
            end
            WAIT_GNT: if (bus.GntDnStr) begin
                grantStb  = 1'b1;
                stateNext = (int'(pkt_count) + 1 == MAX_PKTS) ? DONE : IDLE;
            end
            DONE:    stateNext = DONE;
            default: stateNext = IDLE;
        endcase
    end

    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            packetId      <= '0;
            cnt           <= '0;
            pkt_count     <= '0;
            bus.ReqDnStr  <= 1'b0;
            bus.PacketOut <= '0;
        end else begin
            if (prepStb) begin
                packetId <= packetId + PID_W'(1);
                cnt      <= '0;
            end
            if (cntInc) cnt <= cnt + 4'd1;
            if (loadStb) begin
                bus.PacketOut <= DATA_WIDTH'({xOfs, yOfs, 8'h00, packetId, MODULE_ID});
                bus.ReqDnStr  <= 1'b1;
            end
            if (grantStb) begin
                bus.ReqDnStr <= 1'b0;
                pkt_count    <= pkt_count + PID_W'(1);
            end
        end
    end

    // Per-packet fields are always rewritten in PREP before use, so no reset.
    always_ff @(posedge clk) begin
        if (prepStb) begin
            gap  <= gapNext;
            xOfs <= xOfsNext;
            yOfs <= yOfsNext;
        end
    end
endmodule
